// File: rtl/booth_radix4_multiplier_if.sv
// Operand/result bundle for the radix-4 Booth multiplier.
// The master side supplies operands and the start request; the slave side
// (the multiplier) returns the product and its busy/done status.
interface booth_radix4_multiplier_if #(
  parameter int size = 8
);
  logic              start;
  logic              signed_mode;
  logic [size-1:0]   A;
  logic [size-1:0]   B;
  logic [2*size-1:0] S;
  logic              busy;
  logic              done;

  modport master (
    output start, signed_mode, A, B,
    input  S, busy, done
  );

  modport slave (
    input  start, signed_mode, A, B,
    output S, busy, done
  );
endinterface

// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 (modified Booth) multiplier with built-in controller.
// Operands are extended to an even internal width W so that signed and
// unsigned products share one datapath; two multiplier bits are retired per
// CALC cycle, and the accumulator carries two guard bits so that +/-2M can
// never overflow it.
module booth_radix4_multiplier #(
  parameter int size = 8
) (
  input logic CLOCK,
  input logic RESET,
  booth_radix4_multiplier_if.slave mul
);

  localparam int W  = (size % 2 == 0) ? size + 2 : size + 1;
  localparam int N  = W / 2;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [W-1:0]      m;
  logic [W+1:0]      hi;
  logic [W-1:0]      lo;
  logic              x;
  logic [CW-1:0]     cnt;
  logic [2*size-1:0] result;

  logic [W-1:0]      a_ext;
  logic [W-1:0]      b_ext;
  logic [W+1:0]      m_ext;
  logic [W+1:0]      pp;
  logic [W+1:0]      t;
  logic [W+1:0]      hi_next;
  logic [W-1:0]      lo_next;
  logic              x_next;
  logic [2*size-1:0] product_low;

  // Operand extension: replicate the sign bit only in signed mode.
  assign a_ext = {{(W-size){mul.signed_mode & mul.A[size-1]}}, mul.A};
  assign b_ext = {{(W-size){mul.signed_mode & mul.B[size-1]}}, mul.B};

  // State register; reset always returns to IDLE, aborting any product.
  always_ff @(posedge CLOCK) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: accept start only in IDLE, finish after N steps.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mul.start) state_next = CALC;
      CALC:    if (cnt == CW'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Booth recoding of {LO[1:0], X}, accumulate, then shift right by two.
  always_comb begin
    m_ext = {{2{m[W-1]}}, m};
    pp    = '0;
    case ({lo[1:0], x})
      3'b001, 3'b010: pp = m_ext;
      3'b011:         pp = m_ext << 1;
      3'b100:         pp = -(m_ext << 1);
      3'b101, 3'b110: pp = -m_ext;
      default:        pp = '0;
    endcase
    t           = hi + pp;
    hi_next     = {{2{t[W+1]}}, t[W+1:2]};
    lo_next     = {t[1:0], lo[W-1:2]};
    x_next      = lo[1];
    product_low = (2*size)'({hi_next, lo_next});
  end

  // Datapath registers: capture in IDLE, iterate in CALC, publish on the last step.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      m      <= '0;
      hi     <= '0;
      lo     <= '0;
      x      <= 1'b0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mul.start) begin
            m   <= b_ext;
            lo  <= a_ext;
            hi  <= '0;
            x   <= 1'b0;
            cnt <= CW'(N);
          end
        end
        CALC: begin
          hi  <= hi_next;
          lo  <= lo_next;
          x   <= x_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) result <= product_low;
        end
        default: ;
      endcase
    end
  end

  assign mul.S    = result;
  assign mul.busy = (state != IDLE);
  assign mul.done = (state == DONE);

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Self-checking bench for the radix-4 Booth multiplier: one 8-bit and one
// 7-bit instance, checked against a plain integer-arithmetic product model.
module tb_booth_radix4_multiplier;

  logic clock = 1'b0;
  logic reset8;
  logic reset7;

  int checks   = 0;
  int failures = 0;

  booth_radix4_multiplier_if #(.size(8)) bus8 ();
  booth_radix4_multiplier_if #(.size(7)) bus7 ();

  booth_radix4_multiplier #(.size(8)) dut8 (
    .CLOCK (clock),
    .RESET (reset8),
    .mul   (bus8)
  );

  booth_radix4_multiplier #(.size(7)) dut7 (
    .CLOCK (clock),
    .RESET (reset7),
    .mul   (bus7)
  );

  always #5 clock = ~clock;

  // Reference: interpret operands as w-bit signed/unsigned integers,
  // multiply exactly, keep the low 2*w bits.
  function automatic logic [15:0] ref_product(int w, logic [15:0] a, logic [15:0] b, logic sm);
    longint mask;
    longint ea;
    longint eb;
    longint p;
    mask = (longint'(1) << w) - 1;
    ea = longint'(a) & mask;
    eb = longint'(b) & mask;
    if (sm && ea[w-1]) ea = ea - (longint'(1) << w);
    if (sm && eb[w-1]) eb = eb - (longint'(1) << w);
    p = (ea * eb) & ((longint'(1) << (2*w)) - 1);
    return 16'(p);
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(bit sel7, logic st, logic sm, logic [15:0] a, logic [15:0] b);
    if (sel7) begin
      bus7.start = st; bus7.signed_mode = sm; bus7.A = a[6:0]; bus7.B = b[6:0];
    end else begin
      bus8.start = st; bus8.signed_mode = sm; bus8.A = a[7:0]; bus8.B = b[7:0];
    end
  endtask

  task automatic observe(bit sel7, output logic [15:0] s, output logic bsy, output logic dn);
    if (sel7) begin
      s = {2'b00, bus7.S}; bsy = bus7.busy; dn = bus7.done;
    end else begin
      s = bus8.S; bsy = bus8.busy; dn = bus8.done;
    end
  endtask

  // Runs one product: start accepted at the next edge, operands and start
  // are scrambled while busy, and the cycle in which done appears is returned.
  task automatic run_op(bit sel7, logic [15:0] a, logic [15:0] b, logic sm,
                        output logic [15:0] s, output int lat,
                        output bit busy_all, output bit after_idle);
    logic [15:0] so;
    logic bsy;
    logic dn;
    lat = -1;
    busy_all = 1'b1;
    s = '0;
    drive(sel7, 1'b1, sm, a, b);
    tick;
    for (int c = 1; c <= 40; c++) begin
      observe(sel7, so, bsy, dn);
      if (bsy !== 1'b1) busy_all = 1'b0;
      if (dn === 1'b1) begin
        lat = c;
        s = so;
        break;
      end
      drive(sel7, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
      tick;
    end
    drive(sel7, 1'b0, 1'b0, 16'h0, 16'h0);
    tick;
    observe(sel7, so, bsy, dn);
    after_idle = (bsy === 1'b0) && (dn === 1'b0);
  endtask

  task automatic test_reset;
    reset8 = 1'b1; reset7 = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) tick;
    reset8 = 1'b0; reset7 = 1'b0;
    checks++;
    if ({bus8.S, bus8.busy, bus8.done} !== 18'h0) begin
      failures++;
      $display("[TB] FAIL reset8: got S=%h busy=%b done=%b expected 0/0/0", bus8.S, bus8.busy, bus8.done);
    end
    checks++;
    if ({bus7.S, bus7.busy, bus7.done} !== 16'h0) begin
      failures++;
      $display("[TB] FAIL reset7: got S=%h busy=%b done=%b expected 0/0/0", bus7.S, bus7.busy, bus7.done);
    end
  endtask

  task automatic test_corners8;
    logic [15:0] va [5] = '{16'h80, 16'hFF, 16'hFF, 16'h07, 16'h00};
    logic [15:0] vb [5] = '{16'h80, 16'hFF, 16'hFF, 16'hFD, 16'h5A};
    logic        vs [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] ve [5] = '{16'h4000, 16'hFE01, 16'h0001, 16'hFFEB, 16'h0000};
    logic [15:0] s;
    int lat;
    bit busy_all;
    bit after_idle;
    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, va[i], vb[i], vs[i], s, lat, busy_all, after_idle);
      checks++;
      if (s !== ve[i]) begin
        failures++;
        $display("[TB] FAIL corner8[%0d] S: got %h expected %h", i, s, ve[i]);
      end
      checks++;
      if (lat != 6) begin
        failures++;
        $display("[TB] FAIL corner8[%0d] latency: got %0d expected 6", i, lat);
      end
      checks++;
      if (!busy_all || !after_idle) begin
        failures++;
        $display("[TB] FAIL corner8[%0d] busy/done shape: got busy_all=%0d after_idle=%0d expected 1/1", i, busy_all, after_idle);
      end
    end
  endtask

  task automatic test_size7;
    logic [15:0] s;
    int lat;
    bit busy_all;
    bit after_idle;
    run_op(1'b1, 16'h40, 16'h3F, 1'b1, s, lat, busy_all, after_idle);
    checks++;
    if (s !== 16'h3040 || lat != 5) begin
      failures++;
      $display("[TB] FAIL size7 signed: got S=%h lat=%0d expected S=3040 lat=5", s, lat);
    end
    run_op(1'b1, 16'h40, 16'h3F, 1'b0, s, lat, busy_all, after_idle);
    checks++;
    if (s !== 16'h0FC0 || lat != 5 || !busy_all || !after_idle) begin
      failures++;
      $display("[TB] FAIL size7 unsigned: got S=%h lat=%0d busy_all=%0d after_idle=%0d expected S=0fc0 lat=5 1/1", s, lat, busy_all, after_idle);
    end
  endtask

  task automatic test_random;
    logic [15:0] s;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] e;
    logic sm;
    int lat;
    bit busy_all;
    bit after_idle;
    for (int i = 0; i < 40; i++) begin
      bit sel7;
      sel7 = (i % 2 == 1);
      a  = 16'($urandom);
      b  = 16'($urandom);
      sm = 1'($urandom);
      e  = ref_product(sel7 ? 7 : 8, a, b, sm);
      run_op(sel7, a, b, sm, s, lat, busy_all, after_idle);
      checks++;
      if (s !== e || lat != (sel7 ? 5 : 6) || !busy_all || !after_idle) begin
        failures++;
        $display("[TB] FAIL random[%0d] size=%0d a=%h b=%h sm=%b: got S=%h lat=%0d expected S=%h lat=%0d",
                 i, sel7 ? 7 : 8, a, b, sm, s, lat, e, sel7 ? 5 : 6);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] ha [40];
    logic [15:0] hb [40];
    logic        hs [40];
    logic [15:0] last;
    logic [15:0] e;
    bit expect_done;
    bit drained;
    last = '0;
    for (int t = 0; t < 40; t++) begin
      ha[t] = 16'($urandom);
      hb[t] = 16'($urandom);
      hs[t] = 1'($urandom);
      drive(1'b0, 1'b1, hs[t], ha[t], hb[t]);
      tick;
      expect_done = (t >= 5) && ((t - 5) % 7 == 0);
      checks++;
      if (bus8.done !== expect_done) begin
        failures++;
        $display("[TB] FAIL b2b done at tick %0d: got %b expected %b", t, bus8.done, expect_done);
      end
      if (expect_done) begin
        e = ref_product(8, ha[t-5], hb[t-5], hs[t-5]);
        last = e;
        checks++;
        if (bus8.S !== e) begin
          failures++;
          $display("[TB] FAIL b2b product at tick %0d: got %h expected %h", t, bus8.S, e);
        end
      end else if (t > 5) begin
        checks++;
        if (bus8.S !== last) begin
          failures++;
          $display("[TB] FAIL b2b hold at tick %0d: got %h expected %h", t, bus8.S, last);
        end
      end
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drained = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick;
      if (bus8.busy === 1'b0 && bus8.done === 1'b0) begin
        drained = 1'b1;
        break;
      end
    end
    checks++;
    if (!drained) begin
      failures++;
      $display("[TB] FAIL b2b drain: got busy=%b expected 0 within 20 cycles", bus8.busy);
    end
  endtask

  task automatic test_reset_abort;
    logic [15:0] s;
    int lat;
    bit busy_all;
    bit after_idle;
    bit saw_done;
    drive(1'b0, 1'b1, 1'b0, 16'hC8, 16'h03);
    tick;
    drive(1'b0, 1'b0, 1'b0, 16'hC8, 16'h03);
    tick;
    tick;
    reset8 = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 16'h11, 16'h22);
    tick;
    reset8 = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    checks++;
    if ({bus8.S, bus8.busy, bus8.done} !== 18'h0) begin
      failures++;
      $display("[TB] FAIL abort reset state: got S=%h busy=%b done=%b expected 0/0/0", bus8.S, bus8.busy, bus8.done);
    end
    saw_done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick;
      if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("[TB] FAIL abort no done: got activity after reset expected none");
    end
    run_op(1'b0, 16'hC8, 16'h03, 1'b0, s, lat, busy_all, after_idle);
    checks++;
    if (s !== 16'h0258 || lat != 6) begin
      failures++;
      $display("[TB] FAIL abort restart: got S=%h lat=%0d expected S=0258 lat=6", s, lat);
    end
  endtask

  initial begin
    test_reset;
    test_corners8;
    test_size7;
    test_random;
    test_back_to_back;
    test_reset_abort;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
